// File: rtl/agc_mem_seq.sv
// rtl/agc_mem_seq.sv - AGC erasable-memory access sequencer with fixed/zero-register write protection.
// Optional AGC_EDIT_EN: writes to 12'h010-12'h013 store rotated/shifted data (CYR, SR, CYL, EDOP).
module agc_mem_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [14:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [14:0] rsp_data,
  output logic        err_fixed,
  output logic        err_zero,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [14:0] mem_din,
  input  logic [14:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [14:0] din_q, din_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [14:0] rsp_data_q, rsp_data_d;
  logic        err_fixed_q, err_fixed_d;
  logic        err_zero_q, err_zero_d;

  logic [14:0] edited_wdata;
  logic        accept;
  logic        is_fixed;
  logic        is_zero;

  // Editing registers transform the data on its way into memory, not on readback.
  always_comb begin
    edited_wdata = req_wdata;
`ifdef AGC_EDIT_EN
    case (req_addr)
      12'h010: edited_wdata = {req_wdata[0], req_wdata[14:1]};
      12'h011: edited_wdata = {req_wdata[14], req_wdata[14:1]};
      12'h012: edited_wdata = {req_wdata[13:0], req_wdata[14]};
      12'h013: edited_wdata = {8'b0, req_wdata[13:7]};
      default: edited_wdata = req_wdata;
    endcase
`endif
  end

  assign accept   = req_valid && (state_q == IDLE);
  assign is_fixed = (req_addr[11:10] != 2'b00);
  assign is_zero  = (req_addr == 12'h007);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_fixed_d = err_fixed_q;
    err_zero_d  = err_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d   = req_write;
          addr_d = req_addr;
          din_d  = edited_wdata;
          if (!req_write) begin
            state_d = RD;
          end else if (is_fixed) begin
            // Fixed check wins, so the two error flags are mutually exclusive.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 15'd0;
            err_fixed_d = 1'b1;
          end else if (is_zero) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 15'd0;
            err_zero_d  = 1'b1;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_dout;
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 15'd0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 15'd0;
          err_fixed_d = 1'b0;
          err_zero_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 12'd0;
      din_q       <= 15'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 15'd0;
      err_fixed_q <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_fixed_q <= err_fixed_d;
      err_zero_q  <= err_zero_d;
    end
  end

  // Gating with reset keeps an aborted WR from reaching memory on the reset edge.
  assign mem_we    = (state_q == WR) && wr_q && !reset;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err_fixed = err_fixed_q;
  assign err_zero  = err_zero_q;

endmodule

// File: tb/tb_agc_mem_seq.sv
// tb/tb_agc_mem_seq.sv - directed self-checking bench for agc_mem_seq with a registered-output memory model.
`timescale 1ns/1ps
module tb_agc_mem_seq;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [14:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [14:0] rsp_data;
  logic        err_fixed;
  logic        err_zero;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [14:0] mem_din;
  logic [14:0] mem_dout;

  logic        tb_ld;
  logic [11:0] tb_addr;
  logic [14:0] tb_din;
  logic [14:0] mem [0:4095];

  int tests;
  int fails;

  agc_mem_seq dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .err_fixed (err_fixed),
    .err_zero  (err_zero),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with a registered read port; tb_ld is a back door for preloading.
  always_ff @(posedge clk) begin
    if (tb_ld) mem[tb_addr] <= tb_din;
    else if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [14:0] d);
    tb_ld = 1'b1; tb_addr = a; tb_din = d;
    @(negedge clk);
    tb_ld = 1'b0;
  endtask

  task automatic transact(input logic w, input logic [11:0] a, input logic [14:0] d,
                          input int exp_lat, input logic [14:0] exp_data,
                          input logic exp_ef, input logic exp_ez,
                          input int exp_we, input int hold);
    int lat;
    int we_cnt;
    logic [17:0] obs_s;
    logic [17:0] exp_s;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    lat = 0; we_cnt = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_we) we_cnt++;
    end while (!rsp_valid && lat <= 10);
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("err_fixed", err_fixed, exp_ef);
    chk("err_zero", err_zero, exp_ez);
    chk("mem_we_cycles", we_cnt, exp_we);
    exp_s = {1'b1, exp_data, exp_ef, exp_ez};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      obs_s = {rsp_valid, rsp_data, err_fixed, err_zero};
      chk("rsp_hold", obs_s, exp_s);
      chk("mem_we_hold", mem_we, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("req_ready_in_resp", req_ready, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_s = {15'd0, rsp_valid, err_fixed, err_zero};
    chk("rsp_released", obs_s, 18'd0);
  endtask

  initial begin
    logic [17:0] obs_s;
    tests = 0; fails = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 12'd0;
    req_wdata = 15'd0; rsp_ready = 1'b0;
    tb_ld = 1'b0; tb_addr = 12'd0; tb_din = 15'd0;

    @(negedge clk);
    @(negedge clk);
    chk("reset_mem_we", mem_we, 1'b0);
    load(12'h005, 15'h1234);
    load(12'h007, 15'h0555);
    load(12'hC00, 15'h2222);
    load(12'h031, 15'h0333);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    obs_s = {rsp_valid, rsp_data, err_fixed, err_zero, 1'b0};
    chk("reset_rsp", obs_s, 18'd0);
    chk("reset_mem_addr", mem_addr, 12'd0);
    chk("reset_mem_din", mem_din, 15'd0);

    transact(1'b0, 12'h005, 15'h0000, 3, 15'h1234, 1'b0, 1'b0, 0, 0);

    transact(1'b1, 12'h020, 15'h0ABC, 2, 15'h0000, 1'b0, 1'b0, 1, 0);
    chk("wr_mem_addr", mem_addr, 12'h020);
    chk("wr_mem_din", mem_din, 15'h0ABC);
    transact(1'b0, 12'h020, 15'h0000, 3, 15'h0ABC, 1'b0, 1'b0, 0, 0);

    transact(1'b1, 12'h400, 15'h7FFF, 1, 15'h0000, 1'b1, 1'b0, 0, 0);

    transact(1'b1, 12'h007, 15'h0001, 1, 15'h0000, 1'b0, 1'b1, 0, 0);
    transact(1'b0, 12'h007, 15'h0000, 3, 15'h0555, 1'b0, 1'b0, 0, 0);

    transact(1'b0, 12'hC00, 15'h0000, 3, 15'h2222, 1'b0, 1'b0, 0, 0);

    transact(1'b1, 12'h010, 15'h0001, 2, 15'h0000, 1'b0, 1'b0, 1, 0);
    transact(1'b1, 12'h011, 15'h4002, 2, 15'h0000, 1'b0, 1'b0, 1, 0);
    transact(1'b1, 12'h012, 15'h4001, 2, 15'h0000, 1'b0, 1'b0, 1, 0);
    transact(1'b1, 12'h013, 15'h3F80, 2, 15'h0000, 1'b0, 1'b0, 1, 0);
`ifdef AGC_EDIT_EN
    transact(1'b0, 12'h010, 15'h0000, 3, 15'h4000, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h011, 15'h0000, 3, 15'h6001, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h012, 15'h0000, 3, 15'h0003, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h013, 15'h0000, 3, 15'h007F, 1'b0, 1'b0, 0, 0);
`else
    transact(1'b0, 12'h010, 15'h0000, 3, 15'h0001, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h011, 15'h0000, 3, 15'h4002, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h012, 15'h0000, 3, 15'h4001, 1'b0, 1'b0, 0, 0);
    transact(1'b0, 12'h013, 15'h0000, 3, 15'h3F80, 1'b0, 1'b0, 0, 0);
`endif

    transact(1'b0, 12'h005, 15'h0000, 3, 15'h1234, 1'b0, 1'b0, 0, 5);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h031; req_wdata = 15'h2222;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wr", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_we_gated", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", req_ready, 1'b1);
    obs_s = {rsp_valid, rsp_data, err_fixed, err_zero, 1'b0};
    chk("abort_rsp", obs_s, 18'd0);
    chk("abort_mem_addr", mem_addr, 12'd0);
    chk("abort_mem_din", mem_din, 15'd0);
    @(negedge clk);
    chk("abort_no_rsp", rsp_valid, 1'b0);
    transact(1'b0, 12'h031, 15'h0000, 3, 15'h0333, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
